// File: rtl/comparatore_seq.sv
// comparatore_seq: captures NUM_CH unsigned operands in one handshake, scans
// them one per cycle, and reports the max or min with its channel index plus
// strict-ascending and all-equal flags.
module comparatore_seq #(
    parameter int unsigned WIDTH  = 3,
    parameter int unsigned NUM_CH = 3,
    localparam int unsigned IDXW  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic                    in_mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_value,
    output logic [IDXW-1:0]         out_index,
    output logic                    out_ascending,
    output logic                    out_equal
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDXW-1:0] LAST_PTR = IDXW'(NUM_CH - 1);

    state_t                  state;
    logic [NUM_CH*WIDTH-1:0] data_q;
    logic                    mode_q;
    logic [WIDTH-1:0]        best;
    logic [IDXW-1:0]         idx;
    logic                    asc;
    logic                    eq;
    logic [IDXW-1:0]         ptr;
    logic                    fin;

    logic [WIDTH-1:0]        cur_x;
    logic [WIDTH-1:0]        prev_x;
    logic [WIDTH-1:0]        ch0_x;
    logic                    take;

    // Ready only while idle and out of reset; forced low during reset.
    assign in_ready = rst_n && (state == IDLE);

    // Operand taps for the scan pointer and its predecessor.
    always_comb begin
        int unsigned base_cur;
        int unsigned base_prev;
        base_cur  = 32'(ptr) * WIDTH;
        base_prev = (ptr == '0) ? 32'd0 : (32'(ptr) - 32'd1) * WIDTH;
        cur_x     = data_q[base_cur  +: WIDTH];
        prev_x    = data_q[base_prev +: WIDTH];
        ch0_x     = data_q[WIDTH-1:0];
        take      = mode_q ? (cur_x < best) : (cur_x > best);
    end

    // FSM: capture, scan one channel per cycle, then present and hold the result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            out_valid     <= 1'b0;
            out_value     <= '0;
            out_index     <= '0;
            out_ascending <= 1'b0;
            out_equal     <= 1'b0;
            data_q        <= '0;
            mode_q        <= 1'b0;
            best          <= '0;
            idx           <= '0;
            asc           <= 1'b0;
            eq            <= 1'b0;
            ptr           <= '0;
            fin           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_q <= in_data;
                        mode_q <= in_mode;
                        best   <= in_data[WIDTH-1:0];
                        idx    <= '0;
                        asc    <= 1'b1;
                        eq     <= 1'b1;
                        ptr    <= IDXW'(1);
                        fin    <= 1'b0;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (fin) begin
                        // Final edge of the scan publishes the accumulated result.
                        out_value     <= best;
                        out_index     <= idx;
                        out_ascending <= asc;
                        out_equal     <= eq;
                        out_valid     <= 1'b1;
                        state         <= DONE;
                    end else begin
                        if (take) begin
                            best <= cur_x;
                            idx  <= ptr;
                        end
                        asc <= asc && (cur_x > prev_x);
                        eq  <= eq && (cur_x == ch0_x);
                        if (ptr == LAST_PTR) begin
                            fin <= 1'b1;
                        end else begin
                            ptr <= ptr + IDXW'(1);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comparatore_seq.sv
// Directed bench for comparatore_seq: default 3x3-bit instance plus an
// 8-bit, 5-channel instance for width/depth generality.
module tb_comparatore_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Default instance: WIDTH=3, NUM_CH=3
    logic       a_in_valid, a_in_ready, a_in_mode;
    logic [8:0] a_in_data;
    logic       a_out_valid, a_out_ready;
    logic [2:0] a_out_value;
    logic [1:0] a_out_index;
    logic       a_out_asc, a_out_eq;

    // Wide instance: WIDTH=8, NUM_CH=5
    logic        b_in_valid, b_in_ready, b_in_mode;
    logic [39:0] b_in_data;
    logic        b_out_valid, b_out_ready;
    logic [7:0]  b_out_value;
    logic [2:0]  b_out_index;
    logic        b_out_asc, b_out_eq;

    comparatore_seq #(.WIDTH(3), .NUM_CH(3)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_mode(a_in_mode),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_value(a_out_value), .out_index(a_out_index),
        .out_ascending(a_out_asc), .out_equal(a_out_eq)
    );

    comparatore_seq #(.WIDTH(8), .NUM_CH(5)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_mode(b_in_mode),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_value(b_out_value), .out_index(b_out_index),
        .out_ascending(b_out_asc), .out_equal(b_out_eq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Send one bundle to instance A, measure latency, check result, drain.
    task automatic run_a(input string tag, input logic [2:0] d0, input logic [2:0] d1,
                         input logic [2:0] d2, input logic mode, input int ev,
                         input int ei, input int easc, input int eeq);
        int cnt;
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'(a_in_ready), 32'd1);
        a_in_data  = {d2, d1, d0};
        a_in_mode  = mode;
        a_in_valid = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0;
        a_in_data  = 9'h1ff;
        cnt = 0;
        while (!a_out_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk({tag, "_latency"}, 32'(cnt), 32'd3);
        chk({tag, "_value"},   32'(a_out_value), 32'(ev));
        chk({tag, "_index"},   32'(a_out_index), 32'(ei));
        chk({tag, "_asc"},     32'(a_out_asc),   32'(easc));
        chk({tag, "_eq"},      32'(a_out_eq),    32'(eeq));
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
        chk({tag, "_drained"}, 32'(a_out_valid), 32'd0);
    endtask

    // Send one bundle to instance B, measure latency, check result, drain.
    task automatic run_b(input string tag, input logic [39:0] data, input logic mode,
                         input int ev, input int ei);
        int cnt;
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'(b_in_ready), 32'd1);
        b_in_data  = data;
        b_in_mode  = mode;
        b_in_valid = 1'b1;
        @(negedge clk);
        b_in_valid = 1'b0;
        b_in_data  = '0;
        cnt = 0;
        while (!b_out_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk({tag, "_latency"}, 32'(cnt), 32'd5);
        chk({tag, "_value"},   32'(b_out_value), 32'(ev));
        chk({tag, "_index"},   32'(b_out_index), 32'(ei));
        chk({tag, "_asc"},     32'(b_out_asc),   32'd0);
        chk({tag, "_eq"},      32'(b_out_eq),    32'd0);
        b_out_ready = 1'b1;
        @(negedge clk);
        b_out_ready = 1'b0;
        chk({tag, "_drained"}, 32'(b_out_valid), 32'd0);
    endtask

    initial begin
        int cnt;
        rst_n       = 1'b0;
        a_in_valid  = 1'b0; a_in_mode = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        b_in_valid  = 1'b0; b_in_mode = 1'b0; b_in_data = '0; b_out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  32'(a_in_ready),  32'd0);
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_out_value", 32'(a_out_value), 32'd0);
        chk("rst_out_index", 32'(a_out_index), 32'd0);
        chk("rst_out_asc",   32'(a_out_asc),   32'd0);
        chk("rst_out_eq",    32'(a_out_eq),    32'd0);
        chk("rst_b_valid",   32'(b_out_valid), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(a_in_ready), 32'd1);

        // Main function, default instance
        run_a("asc_max", 3'd0, 3'd5 - 3'd2, 3'd5, 1'b0, 5, 2, 1, 0);
        run_a("min_first", 3'd1, 3'd7, 3'd5, 1'b1, 1, 0, 0, 0);
        run_a("tie_min", 3'd3, 3'd3, 3'd4, 1'b1, 3, 0, 0, 0);
        run_a("tie_max", 3'd3, 3'd3, 3'd4, 1'b0, 4, 2, 0, 0);
        run_a("all_eq", 3'd6, 3'd6, 3'd6, 1'b0, 6, 0, 0, 1);

        // Backpressure: hold result for 5 cycles with a competing bundle offered
        @(negedge clk);
        a_in_data = {3'd1, 3'd5, 3'd3}; a_in_mode = 1'b0; a_in_valid = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0;
        cnt = 0;
        while (!a_out_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("bp_latency", 32'(cnt), 32'd3);
        a_in_data = {3'd7, 3'd7, 3'd7}; a_in_mode = 1'b1; a_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid",    32'(a_out_valid), 32'd1);
            chk("bp_value",    32'(a_out_value), 32'd5);
            chk("bp_index",    32'(a_out_index), 32'd1);
            chk("bp_in_ready", 32'(a_in_ready),  32'd0);
            @(negedge clk);
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
        chk("bp_drain_valid", 32'(a_out_valid), 32'd0);
        chk("bp_drain_ready", 32'(a_in_ready),  32'd1);
        repeat (4) @(negedge clk);
        chk("bp_no_ghost", 32'(a_out_valid), 32'd0);

        // Reset during SCAN discards the operation
        @(negedge clk);
        a_in_data = {3'd1, 3'd4, 3'd3}; a_in_mode = 1'b0; a_in_valid = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0;
        chk("mid_in_scan", 32'(a_in_ready), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready", 32'(a_in_ready),  32'd0);
        chk("mid_rst_valid", 32'(a_out_valid), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("mid_rel_ready", 32'(a_in_ready), 32'd1);
        repeat (5) @(negedge clk);
        chk("mid_no_result", 32'(a_out_valid), 32'd0);
        run_a("post_rst", 3'd1, 3'd4, 3'd5, 1'b1, 1, 0, 1, 0);

        // Width/depth generality: (10,200,200,7,255)
        run_b("w8_min", {8'd255, 8'd7, 8'd200, 8'd200, 8'd10}, 1'b1, 7, 3);
        run_b("w8_max", {8'd255, 8'd7, 8'd200, 8'd200, 8'd10}, 1'b0, 255, 4);

        $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
        $finish;
    end

endmodule
